gpio_in_filter: RTL and testbench

GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

---
 rtl/gpio_in_filter.sv | 121 ++++++++++++
 tb/tb_gpio_in_filter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gpio_in_filter
//  Purpose  : Synchronises and debounces raw GPIO pad inputs. Each bit has its
//             own mismatch counter and its own sticky change flag. The flags
//             are combined with a per-bit mask into a single interrupt line.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1           single clock, rising edge
//    rst        in   1           asynchronous, active-low reset
//    pad_in     in   DATA_WIDTH  raw, asynchronous external pins
//    clr_en     in   1           flag-clear write strobe
//    clr_mask   in   DATA_WIDTH  write-1-to-clear mask, used when clr_en=1
//    irq_mask   in   DATA_WIDTH  per-bit interrupt enable
//    gpio_in_db out  DATA_WIDTH  debounced level (registered)
//    edge_flags out  DATA_WIDTH  sticky per-bit change flags (registered)
//    irq        out  1           OR of (edge_flags AND irq_mask), combinational
// ============================================================================
module gpio_in_filter #(
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4   // legal range 1..255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pad_in,
  input  logic                  clr_en,
  input  logic [DATA_WIDTH-1:0] clr_mask,
  input  logic [DATA_WIDTH-1:0] irq_mask,
  output logic [DATA_WIDTH-1:0] gpio_in_db,
  output logic [DATA_WIDTH-1:0] edge_flags,
  output logic                  irq
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, but is sized from
  // DEBOUNCE_CYCLES+1 so it never collapses to zero width.
  localparam int c_cnt_w_raw = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_cnt_w     = (c_cnt_w_raw < 1) ? 1 : c_cnt_w_raw;

  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]              sync1_q, sync1_d;
  logic [DATA_WIDTH-1:0]              sync2_q, sync2_d;
  logic [DATA_WIDTH-1:0][c_cnt_w-1:0] cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0]              db_q,    db_d;
  logic [DATA_WIDTH-1:0]              flags_q, flags_d;

  // Combinational helpers
  logic [DATA_WIDTH-1:0]              db_change;
  logic [DATA_WIDTH-1:0]              clr_vec;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    sync1_d   = pad_in;
    sync2_d   = sync1_q;
    cnt_d     = cnt_q;
    db_d      = db_q;
    db_change = '0;
    clr_vec   = '0;
    flags_d   = flags_q;

    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        // Input agrees with the accepted level: any partial count is dropped,
        // which is what rejects short glitches.
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= c_cnt_max) begin
        // Final mismatch cycle: accept the new level and restart counting.
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + c_cnt_one;
      end
    end

    db_change = db_d ^ db_q;

    if (clr_en) begin
      clr_vec = clr_mask;
    end

    // Set is OR-ed in after the clear so a simultaneous change wins.
    flags_d = (flags_q & ~clr_vec) | db_change;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      db_q    <= '0;
      flags_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      flags_q <= flags_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign gpio_in_db = db_q;
  assign edge_flags = flags_q;
  assign irq        = |(flags_q & irq_mask);

endmodule

`default_nettype wire

// File: tb/tb_gpio_in_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_in_filter
//  Purpose  : Self-checking bench for gpio_in_filter. Directed scenarios are
//             followed by a randomized run; every cycle is compared against
//             a reference model that keeps a history of pad samples and
//             accepts a new level when the last DEBOUNCE_CYCLES synchronised
//             samples all disagree with the current debounced level.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpio_in_filter;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pad_in;
  logic         clr_en;
  logic [W-1:0] clr_mask;
  logic [W-1:0] irq_mask;
  logic [W-1:0] gpio_in_db;
  logic [W-1:0] edge_flags;
  logic         irq;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] hist[$];   // pad values sampled at past rising edges
  logic [W-1:0] m_db;
  logic [W-1:0] m_flags;

  gpio_in_filter #(
    .DATA_WIDTH      (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pad_in     (pad_in),
    .clr_en     (clr_en),
    .clr_mask   (clr_mask),
    .irq_mask   (irq_mask),
    .gpio_in_db (gpio_in_db),
    .edge_flags (edge_flags),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reset leaves the synchroniser holding zeros, equivalent to a history of
  // zero samples.
  task automatic model_reset();
    m_db    = '0;
    m_flags = '0;
    hist.delete();
    repeat (D + 1) hist.push_back('0);
  endtask

  // The value compared at an edge is the pad sampled two edges earlier, so
  // the last D compared values are hist[size-1-D .. size-2].
  task automatic model_edge();
    logic [W-1:0] all_diff;
    logic [W-1:0] clr;
    all_diff = '1;
    for (int k = 1; k <= D; k++) begin
      all_diff &= hist[hist.size() - 1 - k] ^ m_db;
    end
    clr     = clr_en ? clr_mask : '0;
    m_flags = (m_flags & ~clr) | all_diff;
    m_db    = m_db ^ all_diff;
    hist.push_back(pad_in);
    if (hist.size() > D + 1) void'(hist.pop_front());
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".db"},    gpio_in_db, m_db);
    chk({tag, ".flags"}, edge_flags, m_flags);
    chk({tag, ".irq"},   W'(irq),    W'(|(m_flags & irq_mask)));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_db"},    gpio_in_db, '0);
    chk({tag, ".rst_flags"}, edge_flags, '0);
    chk({tag, ".rst_irq"},   W'(irq),    '0);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    pad_in   = '0;
    clr_en   = 1'b0;
    clr_mask = '0;
    irq_mask = 8'hFF;
    model_reset();
    #3;
    do_reset("init");

    // Held level appears after exactly 2+D edges
    pad_in = 8'h01;
    repeat (5) step("lat");
    chk("lat.db_edge5", gpio_in_db, 8'h00);
    step("lat");
    chk("lat.db_edge6", gpio_in_db, 8'h01);
    chk("lat.flags",    edge_flags, 8'h01);
    chk("lat.irq",      W'(irq),    8'h01);

    // Falling acceptance, then clear, then a 3-cycle glitch is rejected
    pad_in = 8'h00;
    repeat (6) step("fall");
    chk("fall.db", gpio_in_db, 8'h00);
    clr_en = 1'b1; clr_mask = 8'hFF;
    step("clrall");
    clr_en = 1'b0;
    pad_in = 8'h01;
    repeat (3) step("glitch");
    pad_in = 8'h00;
    repeat (8) step("glitch");
    chk("glitch.db",    gpio_in_db, 8'h00);
    chk("glitch.flags", edge_flags, 8'h00);

    // Partial clear
    pad_in = 8'h03;
    repeat (6) step("two");
    chk("two.flags", edge_flags, 8'h03);
    clr_en = 1'b1; clr_mask = 8'h01;
    step("pclr");
    clr_en = 1'b0;
    chk("pclr.flags", edge_flags, 8'h02);

    // Set wins over a simultaneous clear
    pad_in = 8'h01;
    clr_en = 1'b1; clr_mask = 8'hFF;
    step("sw");
    clr_en = 1'b0;
    chk("sw.cleared", edge_flags, 8'h00);
    repeat (4) step("sw");
    clr_en = 1'b1; clr_mask = 8'h02;
    step("sw");
    clr_en = 1'b0;
    chk("sw.db",    gpio_in_db, 8'h01);
    chk("sw.flags", edge_flags, 8'h02);

    // clr_en=0 ignores clr_mask
    clr_mask = 8'hFF;
    step("noclr");
    chk("noclr.flags", edge_flags, 8'h02);

    // Interrupt masking is combinational and leaves flags alone
    clr_en = 1'b1; clr_mask = 8'hFF;
    step("mclr");
    clr_en = 1'b0;
    pad_in = 8'h81;
    repeat (6) step("b7");
    chk("b7.flags", edge_flags, 8'h80);
    irq_mask = 8'h7F;
    #1;
    chk("mask.irq0",  W'(irq),    8'h00);
    chk("mask.flags", edge_flags, 8'h80);
    irq_mask = 8'hFF;
    #1;
    chk("mask.irq1", W'(irq), 8'h01);

    // Reset mid-debounce discards partial counts
    do_reset("pre");
    pad_in = 8'hFF;
    repeat (4) step("mid");
    do_reset("mid");
    repeat (5) step("post");
    chk("post.db_edge5", gpio_in_db, 8'h00);
    chk("post.flags5",   edge_flags, 8'h00);
    step("post");
    chk("post.db_edge6", gpio_in_db, 8'hFF);

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(2) == 0) pad_in = W'($urandom);
      clr_en   = ($urandom_range(3) == 0);
      clr_mask = W'($urandom);
      if ($urandom_range(7) == 0) irq_mask = W'($urandom);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
